// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants, micro-op enumeration and request payload.
// The control decoder imports the same package, so both sides always agree on the field values.
package mips_defs;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_LUI   = 6'b001111;
    localparam logic [OPC_W-1:0] OPC_JAL   = 6'b000011;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_JR  = 6'b001000;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_ORI = 4'd3,
        OP_LW  = 4'd4,
        OP_SW  = 4'd5,
        OP_BEQ = 4'd6,
        OP_LUI = 4'd7,
        OP_JAL = 4'd8,
        OP_JR  = 4'd9
    } op_e;

    // Op is kept as raw bits: codes 10..15 must still be representable.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-word handshake ports of the instruction encoder.
interface instr_encoder_if;
    import mips_defs::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      in_op;
    logic [REG_W-1:0]     in_rs;
    logic [REG_W-1:0]     in_rt;
    logic [REG_W-1:0]     in_rd;
    logic [IMM_W-1:0]     in_imm;
    logic [TGT_W-1:0]     in_target;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic [ADDR_W-1:0]    out_addr;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Circular-buffer FIFO: storage, pointers and occupancy only; head is shown combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty gates the head to zero.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic micro-ops into MIPS words, buffers them and tags each with its IM byte address.
module instr_encoder
    import mips_defs::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    instr_encoder_if.slave         bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_illegal
);
    req_t               req;
    logic [INSTR_W-1:0] word;
    logic               accept, illegal, push, pop;
    logic               full, empty;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    // Fields an op does not use stay zero whatever the request carried.
    function automatic logic [INSTR_W-1:0] encode(input req_t r);
        logic [INSTR_W-1:0] w;
        w = '0;
        case (r.op)
            OP_ADD:  w = {OPC_RTYPE, r.rs, r.rt, r.rd, SHAMT_W'(0), FN_ADD};
            OP_SUB:  w = {OPC_RTYPE, r.rs, r.rt, r.rd, SHAMT_W'(0), FN_SUB};
            OP_JR:   w = {OPC_RTYPE, r.rs, REG_W'(0), REG_W'(0), SHAMT_W'(0), FN_JR};
            OP_ORI:  w = {OPC_ORI, r.rs, r.rt, r.imm};
            OP_LW:   w = {OPC_LW,  r.rs, r.rt, r.imm};
            OP_SW:   w = {OPC_SW,  r.rs, r.rt, r.imm};
            OP_BEQ:  w = {OPC_BEQ, r.rs, r.rt, r.imm};
            OP_LUI:  w = {OPC_LUI, REG_W'(0), r.rt, r.imm};
            OP_JAL:  w = {OPC_JAL, r.target};
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        req     = '{op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                    imm: bus.in_imm, target: bus.in_target};
        word    = encode(req);
        accept  = bus.in_valid && bus.in_ready;
        illegal = (req.op > OP_W'(OP_JR));
        push    = accept && !illegal && !clear;
        pop     = bus.out_valid && bus.out_ready && !clear;
        err_d   = err_q;
        addr_d  = addr_q;
        if (clear) begin
            err_d  = 1'b0;
            addr_d = BASE_ADDR;
        end else begin
            if (accept && illegal) err_d = 1'b1;
            if (pop)               addr_d = addr_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q  <= 1'b0;
            addr_q <= BASE_ADDR;
        end else begin
            err_q  <= err_d;
            addr_q <= addr_d;
        end
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (bus.out_instr),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_addr  = addr_q;
    assign err_illegal   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, backpressure, illegal op, clear and async reset.
module tb_instr_encoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [2:0] count;
    logic       err_illegal;
    int         n_checks = 0;
    int         n_errors = 0;

    instr_encoder_if bus ();

    instr_encoder #(
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .bus         (bus),
        .count       (count),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
    endtask

    // One accept with out_ready high; the word must be at the head on the very next cycle.
    task automatic xfer(input string tag, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] exp, input logic [31:0] exp_addr);
        drive(op, rs, rt, rd, imm, tgt);
        cyc();
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_instr"}, bus.out_instr, exp);
        check({tag, "_addr"}, bus.out_addr, exp_addr);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ovalid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_instr"}, bus.out_instr, 32'h0);
        check({tag, "_addr"}, bus.out_addr, 32'h0000_3000);
        check({tag, "_err"}, 32'(err_illegal), 32'd0);
        check({tag, "_iready"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [31:0] exp3 [5];
    int          k;
    logic        acc;

    initial begin
        exp3[0] = 32'h0022_0820;
        exp3[1] = 32'h0022_1020;
        exp3[2] = 32'h0022_1820;
        exp3[3] = 32'h0022_2020;
        exp3[4] = 32'h0022_2820;

        reset = 1'b0;
        clear = 1'b0;
        bus.out_ready = 1'b1;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_state("rst");
        reset = 1'b1;
        @(negedge clk);

        // Encodings and address sequence, one word per cycle
        xfer("add", 4'd1, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h0022_1820, 32'h0000_3000);
        xfer("sub", 4'd2, 5'd1,  5'd2,  5'd3,  16'hABCD, 26'h0,       32'h0022_1822, 32'h0000_3004);
        xfer("ori", 4'd3, 5'd0,  5'd1,  5'd9,  16'h1234, 26'h0,       32'h3401_1234, 32'h0000_3008);
        xfer("lui", 4'd7, 5'd31, 5'd1,  5'd7,  16'hFFFF, 26'h0,       32'h3C01_FFFF, 32'h0000_300C);
        xfer("sw",  4'd5, 5'd0,  5'd1,  5'd0,  16'h0004, 26'h0,       32'hAC01_0004, 32'h0000_3010);
        xfer("beq", 4'd6, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022_FFFF, 32'h0000_3014);
        xfer("jal", 4'd8, 5'd5,  5'd6,  5'd7,  16'h5555, 26'h0000C03, 32'h0C00_0C03, 32'h0000_3018);
        xfer("jr",  4'd9, 5'd31, 5'd3,  5'd4,  16'h1111, 26'h3FFFFFF, 32'h03E0_0008, 32'h0000_301C);
        xfer("nop", 4'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0000_0000, 32'h0000_3020);
        xfer("lw",  4'd4, 5'd29, 5'd8,  5'd3,  16'h8000, 26'h0,       32'h8FA8_8000, 32'h0000_3024);
        cyc();
        check("drain_count", 32'(count), 32'd0);

        // Backpressure: fill, hold a fifth request, then drain in order
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_addr", bus.out_addr, 32'h0000_3000);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'd1, 5'd1, 5'd2, 5'(i + 1), 16'h0, 26'h0);
            cyc();
        end
        drive(4'd1, 5'd1, 5'd2, 5'd5, 16'h0, 26'h0);
        check("bp_full_count", 32'(count), 32'd4);
        check("bp_full_iready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("bp_stall_count", 32'(count), 32'd4);
            check("bp_stall_instr", bus.out_instr, exp3[0]);
            check("bp_stall_addr", bus.out_addr, 32'h0000_3000);
        end
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check("bp_order", bus.out_instr, exp3[k]);
                check("bp_addr", bus.out_addr, 32'h0000_3000 + 32'(4 * k));
                k++;
            end
            @(posedge clk);
            #1;
            if (acc) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("bp_drained", 32'(k), 32'd5);
        check("bp_in_consumed", 32'(bus.in_valid), 32'd0);

        // Illegal op between two adds
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        xfer("ill_a1", 4'd1, 5'd1, 5'd2, 5'd1, 16'h0, 26'h0, 32'h0022_0820, 32'h0000_3000);
        drive(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        check("ill_iready", 32'(bus.in_ready), 32'd1);
        cyc();
        check("ill_err", 32'(err_illegal), 32'd1);
        check("ill_count", 32'(count), 32'd0);
        check("ill_ovalid", 32'(bus.out_valid), 32'd0);
        xfer("ill_a2", 4'd1, 5'd1, 5'd2, 5'd2, 16'h0, 26'h0, 32'h0022_1020, 32'h0000_3004);
        cyc();
        check("ill_two_words", 32'(bus.out_valid), 32'd0);

        // Clear with three buffered words and a request pending
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
            cyc();
        end
        check("clr_pre_count", 32'(count), 32'd3);
        check("clr_pre_err", 32'(err_illegal), 32'd1);
        clear = 1'b1;
        check("clr_iready", 32'(bus.in_ready), 32'd1);
        cyc();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovalid", 32'(bus.out_valid), 32'd0);
        check("clr_err", 32'(err_illegal), 32'd0);
        bus.out_ready = 1'b1;
        xfer("clr_next", 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820, 32'h0000_3000);

        // Asynchronous reset between edges with words buffered and the sticky flag set
        bus.out_ready = 1'b0;
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        cyc();
        drive(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        cyc();
        bus.in_valid = 1'b0;
        check("mid_count", 32'(count), 32'd2);
        check("mid_err", 32'(err_illegal), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_state("arst");
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        xfer("post_rst", 4'd3, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'h0, 32'h3443_00FF, 32'h0000_3000);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Produces 32-bit MIPS instruction words from symbolic micro-op requests. It is the write side of the opcode/funct decode path.
- Requests arrive on a valid/ready port, are encoded into the binary format the control decoder consumes, and are buffered in a small FIFO.
- Words leave on a second valid/ready port, tagged with a sequential instruction-memory address, to load IM for self-check benches and boot images.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_3000: address attached to the first emitted word after reset or clear.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- clear  in  1  synchronous flush: empties the FIFO and reloads the address to BASE_ADDR.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- in_op  in  4  0 nop, 1 add, 2 sub, 3 ori, 4 lw, 5 sw, 6 beq, 7 lui, 8 jal, 9 jr, 10–15 illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jal target.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded word.
- out_addr  out  32  IM byte address of out_instr.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- err_illegal  out  1  sticky: an illegal op was accepted.

Behaviour:
Reset values (reset = 0, asynchronous):
- FIFO empty, count 0, out_valid 0, out_instr 0.
- out_addr BASE_ADDR, err_illegal 0, in_ready 1.

Encoding, registered into the FIFO on the accept cycle (all fields are zero unless listed):
- nop: 32'h0.
- add: opcode 000000, rs, rt, rd, shamt 0, funct 100000.
- sub: as add, funct 100010.
- jr: opcode 000000, rs, funct 001000.
- ori: opcode 001101, rs, rt, imm.
- lw: opcode 100011, rs, rt, imm.
- sw: opcode 101011, rs, rt, imm.
- beq: opcode 000100, rs, rt, imm.
- lui: opcode 001111, rs forced 0, rt, imm.
- jal: opcode 000011, target.
- Unused fields are forced to 0 regardless of the input values.

Handshake and timing:
- in_ready = !full. There is no same-cycle bypass when full.
- An illegal op is accepted (handshake completes), is not written to the FIFO, and sets err_illegal. err_illegal is cleared only by reset or clear.
- Latency: a word accepted in cycle N is visible on out_* in cycle N+1 at the earliest.
- out_valid = !empty. out_instr is the FIFO head.
- While out_valid is high and out_ready is low, out_instr and out_addr stay stable.
- out_addr increments by 4 on each output handshake and wraps modulo 2^32.

Simultaneous events:
- Push and pop in the same cycle: count unchanged. A pop is possible when full, but no push occurs, because in_ready was 0.
- Push when empty: out_valid rises the next cycle.
- clear has priority over push and pop in the same cycle:
  - FIFO emptied, out_addr = BASE_ADDR, err_illegal = 0.
  - The concurrent request is dropped.
  - in_ready remains 1 during clear.
- Reset mid-stream discards all buffered words immediately.

FIFO:
- Circular buffer with read and write pointers clog2(DEPTH) bits wide, wrapping naturally.
- count tracks occupancy; full = (count == DEPTH), empty = (count == 0).

Decomposition:
- Shared package (mips_defs): opcode constants (000000, 001101, 100011, 101011, 000100, 001111, 000011) and funct constants (100000, 100010, 001000).
  - These are the same values the control decoder uses, so encode and decode share one definition.
  - The in_op enumeration also lives here.
- Sub-module: sync_fifo (parameters WIDTH, DEPTH). It contains the storage and pointer logic only.
- instr_encoder holds the combinational encode function, the illegal flag and the address counter.

Test Plan:
1. Encodings, with out_ready high:
   - add rs=1 rt=2 rd=3 -> 32'h00221820.
   - sub rs=1 rt=2 rd=3 -> 32'h00221822.
   - ori rs=0 rt=1 imm=16'h1234 -> 32'h34011234.
   - lui rt=1 imm=16'hFFFF, with in_rs=31 -> 32'h3C01FFFF.
   - Each word appears one cycle after its accept.
2. Remaining ops:
   - sw rs=0 rt=1 imm=4 -> 32'hAC010004.
   - beq rs=1 rt=2 imm=16'hFFFF -> 32'h1022FFFF.
   - jal target=26'h0000C03 -> 32'h0C000C03.
   - jr rs=31 -> 32'h03E00008.
   - nop -> 32'h00000000.
   - out_addr steps 3000, 3004, 3008, ….
3. Backpressure:
   - Hold out_ready=0 and push 5 requests: in_ready drops after the 4th (count=4); the 5th is held and not lost.
   - Raise out_ready: all 5 words emerge in order, out_instr stays stable while stalled.
4. Illegal op:
   - Push op=12 between two adds: handshake completes, err_illegal=1.
   - Exactly 2 words are emitted, with addresses 3000 and 3004.
5. clear while count=3 and in_valid high: next cycle count=0, out_valid=0, err_illegal=0, and the next emitted word has out_addr 3000.
6. Reset:
   - Assert reset=0 asynchronously mid-stream, between clock edges: outputs return to reset values before the next edge.
   - After release, the first word is tagged 32'h00003000.
